// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for a dual-clock FIFO.
// Produces RAM write strobe/address, the Gray write pointer and wr_clk-domain status flags.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2
) (
  input  logic                  wr_clk,
  input  logic                  rst_in,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  wr_ack,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] wr_ptr_bin;
  logic [PW-1:0] wr_ptr_bin_next;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] cnt_n;
  logic [PW-1:0] free_n;
  logic          accept;

  (* ASYNC_REG = "TRUE" *) logic [PW-1:0] rd_sync_q [SYNC_STAGES];

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // full is held high through reset, so nothing is accepted while rst_in=1.
  assign accept  = wr_en & ~full;
  assign mem_we  = accept;
  assign wr_addr = wr_ptr_bin[ADDR_WIDTH-1:0];

  assign wr_ptr_bin_next = wr_ptr_bin + {{ADDR_WIDTH{1'b0}}, accept};
  assign rd_bin_s        = gray2bin(rd_sync_q[SYNC_STAGES-1]);
  assign cnt_n           = wr_ptr_bin_next - rd_bin_s;
  assign free_n          = PW'(DEPTH) - cnt_n;

  // NOTE: every sequential assignment uses <= so all flops sample pre-edge values
  // together; blocking assignments here would create ordering-dependent races.
  // NOTE: the synchroniser array is reset too, so a restarted FIFO never compares
  // against a stale read pointer left over from before reset.
  always_ff @(posedge wr_clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rd_sync_q[i] <= '0;
      end
    end else begin
      rd_sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rd_sync_q[i] <= rd_sync_q[i-1];
      end
    end
  end

  // Flags come from next-state values so full rises on the very write that fills the FIFO.
  always_ff @(posedge wr_clk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      wr_count    <= '0;
      full        <= 1'b1;
      almost_full <= 1'b1;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr_bin  <= wr_ptr_bin_next;
      wr_ptr_gray <= wr_ptr_bin_next ^ (wr_ptr_bin_next >> 1);
      wr_count    <= cnt_n;
      full        <= (cnt_n == PW'(DEPTH));
      almost_full <= (free_n <= PW'(AF_THRESH));
      wr_ack      <= accept;
      overflow    <= wr_en & full;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised self-checking bench for fifo_wr_ctrl against an occupancy-level model
// that tracks write count, read pointer delay and flag rules in plain arithmetic.
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MODP  = 32;
  localparam int SYNC  = 2;
  localparam int AF    = 2;

  logic          wr_clk = 1'b0;
  logic          rst_in;
  logic          wr_en;
  logic [AW:0]   rd_ptr_gray;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_count;
  logic          wr_ack;
  logic          overflow;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AF_THRESH(AF)) dut (
    .wr_clk      (wr_clk),
    .rst_in      (rst_in),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .mem_we      (mem_we),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count),
    .wr_ack      (wr_ack),
    .overflow    (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: writes accepted so far (mod 2*DEPTH), the read pointer as it
  // appears after the synchroniser delay, and the flag rules applied to occupancy.
  int unsigned m_wptr;
  int unsigned m_cnt;
  bit          m_full, m_af, m_ack, m_ovf;
  int unsigned rd_q[$];
  int unsigned rd_bin;

  function automatic logic [AW:0] to_gray(input int unsigned b);
    return (AW+1)'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_wptr = 0;
    m_cnt  = 0;
    m_full = 1'b1;
    m_af   = 1'b1;
    m_ack  = 1'b0;
    m_ovf  = 1'b0;
    rd_q   = {};
    repeat (SYNC) rd_q.push_back(0);
  endtask

  function automatic int unsigned true_occ();
    return (m_wptr + MODP - rd_bin) % MODP;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit we);
    bit          acc;
    int unsigned seen;
    wr_en       = we;
    rd_ptr_gray = to_gray(rd_bin);
    #1;
    acc = we && !m_full && !rst_in;
    check("mem_we", 32'(mem_we), 32'(acc));
    if (acc) check("wr_addr", 32'(wr_addr), m_wptr % DEPTH);
    @(posedge wr_clk);
    if (rst_in) begin
      model_reset();
    end else begin
      seen = rd_q.pop_front();
      rd_q.push_back(rd_bin);
      m_ovf = we && m_full;
      m_ack = acc;
      if (acc) m_wptr = (m_wptr + 1) % MODP;
      m_cnt  = (m_wptr + MODP - seen) % MODP;
      m_full = (m_cnt == DEPTH);
      m_af   = (DEPTH - m_cnt) <= AF;
    end
    #1;
    check("full",        32'(full),        32'(m_full));
    check("almost_full", 32'(almost_full), 32'(m_af));
    check("wr_count",    32'(wr_count),    m_cnt);
    check("wr_ack",      32'(wr_ack),      32'(m_ack));
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wptr)));
    @(negedge wr_clk);
  endtask

  initial begin
    rst_in      = 1'b1;
    wr_en       = 1'b0;
    rd_bin      = 0;
    rd_ptr_gray = '0;
    model_reset();
    @(negedge wr_clk);

    // Reset held with random write requests: ignored, flags pinned high.
    repeat (5) step(1'($urandom_range(0, 1)));
    check("rst_full", 32'(full), 32'd1);
    check("rst_af",   32'(almost_full), 32'd1);
    rst_in = 1'b0;
    step(1'b0);
    check("rel_full",  32'(full), 32'd0);
    check("rel_af",    32'(almost_full), 32'd0);
    check("rel_count", 32'(wr_count), 32'd0);

    // Fill from empty with the reader idle.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1);
      if (i == 13) check("af_at_14", 32'(almost_full), 32'd1);
      if (i == 14) check("not_full_15", 32'(full), 32'd0);
    end
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(wr_count), 32'd16);
    check("fill_gray",  32'(wr_ptr_gray), 32'h18);

    // Write attempt while full.
    step(1'b1);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(wr_count), 32'd16);
    step(1'b0);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Read pointer jumps to 4: visible exactly three edges later.
    rd_bin = 4;
    step(1'b0);
    step(1'b0);
    check("lat_full_2", 32'(full), 32'd1);
    step(1'b0);
    check("lat_full_3",  32'(full), 32'd0);
    check("lat_count_3", 32'(wr_count), 32'd12);
    check("lat_af_3",    32'(almost_full), 32'd0);

    // Random traffic with a read side that never passes the write pointer.
    for (int i = 0; i < 400; i++) begin
      if (true_occ() > 0 && $urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 55 : 15))
        rd_bin = (rd_bin + 1) % MODP;
      step(1'($urandom_range(0, 99) < 70));
    end

    // Drive the write pointer up to 31, then write across the wrap.
    for (int i = 0; i < 100 && m_wptr != 31; i++) begin
      if (true_occ() > 2) rd_bin = (rd_bin + 1) % MODP;
      step(1'b1);
    end
    check("wrap_pre", m_wptr, 32'd31);
    if (true_occ() > 2) rd_bin = (rd_bin + 1) % MODP;
    check("wrap_addr_15", 32'(wr_addr), 32'd15);
    step(1'b1);
    check("wrap_gray", 32'(wr_ptr_gray), 32'h00);
    check("wrap_addr_0", 32'(wr_addr), 32'd0);

    // Asynchronous reset in the middle of a write stream.
    repeat (6) begin
      if (true_occ() > 3) rd_bin = (rd_bin + 1) % MODP;
      step(1'b1);
    end
    wr_en = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_full",   32'(full), 32'd1);
    check("arst_af",     32'(almost_full), 32'd1);
    check("arst_count",  32'(wr_count), 32'd0);
    check("arst_gray",   32'(wr_ptr_gray), 32'd0);
    check("arst_addr",   32'(wr_addr), 32'd0);
    model_reset();
    rd_bin = 0;
    @(negedge wr_clk);
    repeat (3) step(1'b1);
    rst_in = 1'b0;
    step(1'b1);
    check("resume_addr", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (true_occ() > 0 && $urandom_range(0, 1) == 1) rd_bin = (rd_bin + 1) % MODP;
      step(1'($urandom_range(0, 99) < 80));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
